// File: rtl/io_pkg.sv
// Shared widths, defaults and output-path state encoding for the terminal I/O stage.
package io_pkg;
  localparam int IO_DATA_W             = 8;
  localparam int IO_FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_BUSY = 1'b1
  } out_state_t;
endpackage

// File: rtl/io_fifo.sv
// Synchronous circular FIFO with head-of-queue output; DEPTH must be a power of two.
module io_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = IO_FIFO_DEPTH_DEFAULT,
  parameter int W     = IO_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage contents are don't-care after reset, so no reset branch here.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/io_port_unit.sv
// Terminal I/O stage: keyboard buffer feeding INPR, printer register OUTR with FGO,
// and the IEN interrupt-enable flop with its interrupt request.
//
//   state    | meaning
//   OUT_IDLE | OUTR free, FGO=1, waiting for an OUT instruction
//   OUT_BUSY | OUTR holds a character, prn_valid=1, waiting for the printer
module io_port_unit
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH = IO_FIFO_DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IO_DATA_W-1:0] kbd_data,
  input  logic                 kbd_valid,
  output logic                 kbd_ready,
  input  logic                 inp_read,
  output logic [IO_DATA_W-1:0] INPR,
  output logic                 FGI,
  input  logic [IO_DATA_W-1:0] out_data,
  input  logic                 out_write,
  output logic [IO_DATA_W-1:0] OUTR,
  output logic                 FGO,
  output logic                 prn_valid,
  input  logic                 prn_ready,
  input  logic                 ion,
  input  logic                 iof,
  input  logic                 irq_ack,
  output logic                 IEN,
  output logic                 irq
);
  logic [IO_DATA_W-1:0]          kbd_head;
  logic [$clog2(FIFO_DEPTH):0]   kbd_count;
  logic                          kbd_full;
  logic                          kbd_empty;
  out_state_t                    out_state;

  io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (IO_DATA_W)
  ) u_kbd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (kbd_valid),
    .push_data (kbd_data),
    .pop       (inp_read),
    .head      (kbd_head),
    .count     (kbd_count),
    .full      (kbd_full),
    .empty     (kbd_empty)
  );

  assign kbd_ready = ~kbd_full;
  assign FGI       = (kbd_count != '0);
  assign INPR      = kbd_empty ? '0 : kbd_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= OUT_IDLE;
      OUTR      <= '0;
    end else begin
      case (out_state)
        OUT_IDLE: begin
          if (out_write) begin
            OUTR      <= out_data;
            out_state <= OUT_BUSY;
          end
        end
        OUT_BUSY: begin
          if (prn_ready) out_state <= OUT_IDLE;
        end
        default: out_state <= OUT_IDLE;
      endcase
    end
  end

  assign FGO       = (out_state == OUT_IDLE);
  assign prn_valid = (out_state == OUT_BUSY);

  // A clear in the same cycle as ION wins, so an interrupt cycle can never re-arm itself.
  always_ff @(posedge clk) begin
    if (rst)                 IEN <= 1'b0;
    else if (iof | irq_ack)  IEN <= 1'b0;
    else if (ion)            IEN <= 1'b1;
  end

  assign irq = IEN & (FGI | FGO);
endmodule
